// File: rtl/aes_round_ctrl_if.sv
// Handshake and datapath bundle for the iterative AES round controller.
// master: the surrounding system (producer, consumer, key schedule, round datapath).
// slave : the controller itself.
interface aes_round_ctrl_if;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_block;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_block;
   logic [3:0]   rk_round_o;
   logic [127:0] rk_i;
   logic [127:0] dp_state_o;
   logic         dp_last_o;
   logic         dp_start_o;
   logic [127:0] dp_result_i;
   logic         busy;

   modport master (
      output in_valid, in_block, out_ready, rk_i, dp_result_i,
      input  in_ready, out_valid, out_block, rk_round_o, dp_state_o,
             dp_last_o, dp_start_o, busy
   );

   modport slave (
      input  in_valid, in_block, out_ready, rk_i, dp_result_i,
      output in_ready, out_valid, out_block, rk_round_o, dp_state_o,
             dp_last_o, dp_start_o, busy
   );
endinterface

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption sequencer: holds the cipher state, performs the
// initial AddRoundKey on accept, then drives the external round datapath once
// per round (mix_columns skipped on the final round) and presents the result.
module aes_round_ctrl #(
   parameter int NR     = 10,
   parameter int DP_LAT = 0
) (
   input logic             clk,
   input logic             rst,
   aes_round_ctrl_if.slave bus
);

   localparam int             WW    = (DP_LAT < 2) ? 1 : $clog2(DP_LAT + 1);
   localparam logic [3:0]     NR4   = 4'(NR);
   localparam logic [WW-1:0]  LAT_W = WW'(DP_LAT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ROUND,
      S_WAIT,
      S_DONE
   } state_t;

   state_t        r_state;
   logic [127:0]  r_state_q;
   logic [3:0]    r_round;
   logic [WW-1:0] r_wait_cnt;
   logic          r_in_ready;
   logic          r_out_valid;
   logic          r_dp_start;
   logic          r_dp_last;
   logic          r_busy;

   logic          w_accept;
   logic          w_final;
   logic [3:0]    w_round_nx;

   assign w_accept   = bus.in_valid & r_in_ready;
   assign w_final    = (r_round == NR4);
   assign w_round_nx = r_round + 4'd1;

   assign bus.in_ready   = r_in_ready;
   assign bus.out_valid  = r_out_valid;
   assign bus.out_block  = r_state_q;
   assign bus.rk_round_o = r_round;
   assign bus.dp_state_o = r_state_q;
   assign bus.dp_last_o  = r_dp_last;
   assign bus.dp_start_o = r_dp_start;
   assign bus.busy       = r_busy;

   // Sequencer FSM with all handshake/datapath controls registered alongside the state.
   // With DP_LAT==0 the controller stays in ROUND and dp_start stays high, one round per cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_state_q   <= '0;
         r_round     <= '0;
         r_wait_cnt  <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_dp_start  <= 1'b0;
         r_dp_last   <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_state_q  <= bus.in_block ^ bus.rk_i;
                  r_round    <= 4'd1;
                  r_state    <= S_ROUND;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
                  r_dp_start <= 1'b1;
                  r_dp_last  <= (NR4 == 4'd1);
               end
            end
            S_ROUND: begin
               if (DP_LAT == 0) begin
                  r_state_q <= bus.dp_result_i;
                  if (w_final) begin
                     r_state     <= S_DONE;
                     r_dp_start  <= 1'b0;
                     r_dp_last   <= 1'b0;
                     r_out_valid <= 1'b1;
                  end else begin
                     r_round   <= w_round_nx;
                     r_dp_last <= (w_round_nx == NR4);
                  end
               end else begin
                  r_wait_cnt <= WW'(1);
                  r_dp_start <= 1'b0;
                  r_state    <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (r_wait_cnt == LAT_W) begin
                  r_state_q  <= bus.dp_result_i;
                  r_wait_cnt <= '0;
                  if (w_final) begin
                     r_state     <= S_DONE;
                     r_dp_last   <= 1'b0;
                     r_out_valid <= 1'b1;
                  end else begin
                     r_round    <= w_round_nx;
                     r_state    <= S_ROUND;
                     r_dp_start <= 1'b1;
                     r_dp_last  <= (w_round_nx == NR4);
                  end
               end else begin
                  r_wait_cnt <= r_wait_cnt + WW'(1);
               end
            end
            S_DONE: begin
               if (bus.out_ready) begin
                  r_state     <= S_IDLE;
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_round     <= '0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: two instances (DP_LAT=0 and DP_LAT=2) wired to a
// behavioural AES round datapath and key schedule; scoreboard queues hold the
// expected ciphertexts, a negedge monitor pops and compares on each output.
module tb_aes_round_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst0, rst1;
   aes_round_ctrl_if if0 ();
   aes_round_ctrl_if if1 ();

   aes_round_ctrl #(.NR(10), .DP_LAT(0)) dut0 (.clk(clk), .rst(rst0), .bus(if0.slave));
   aes_round_ctrl #(.NR(10), .DP_LAT(2)) dut1 (.clk(clk), .rst(rst1), .bus(if1.slave));

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- AES reference pieces ----------------
   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = xt(a);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] sq = x;
      logic [7:0] r  = 8'h01;
      for (int i = 0; i < 7; i++) begin
         sq = gmul(sq, sq);
         r  = gmul(r, sq);
      end
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
   endfunction

   // hex text order (first byte leftmost) -> byte 0 at [7:0]
   function automatic logic [127:0] bswap(input logic [127:0] h);
      logic [127:0] r;
      for (int n = 0; n < 16; n++) r[n*8 +: 8] = h[(15-n)*8 +: 8];
      return r;
   endfunction

   function automatic logic [127:0] round_fn(input logic [127:0] s, input logic [127:0] k, input logic last);
      logic [127:0] sb, sr, mc;
      logic [7:0]   a0, a1, a2, a3;
      for (int n = 0; n < 16; n++) sb[n*8 +: 8] = sbox(s[n*8 +: 8]);
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            sr[(c*4+r)*8 +: 8] = sb[((((c+r)%4)*4)+r)*8 +: 8];
      for (int c = 0; c < 4; c++) begin
         a0 = sr[(c*4+0)*8 +: 8]; a1 = sr[(c*4+1)*8 +: 8];
         a2 = sr[(c*4+2)*8 +: 8]; a3 = sr[(c*4+3)*8 +: 8];
         mc[(c*4+0)*8 +: 8] = gmul(a0, 8'd2) ^ gmul(a1, 8'd3) ^ a2 ^ a3;
         mc[(c*4+1)*8 +: 8] = a0 ^ gmul(a1, 8'd2) ^ gmul(a2, 8'd3) ^ a3;
         mc[(c*4+2)*8 +: 8] = a0 ^ a1 ^ gmul(a2, 8'd2) ^ gmul(a3, 8'd3);
         mc[(c*4+3)*8 +: 8] = gmul(a0, 8'd3) ^ a1 ^ a2 ^ gmul(a3, 8'd2);
      end
      return (last ? sr : mc) ^ k;
   endfunction

   function automatic logic [1407:0] expand(input logic [127:0] key);
      logic [31:0]   w [44];
      logic [31:0]   t;
      logic [7:0]    rc = 8'h01;
      logic [1407:0] o;
      for (int i = 0; i < 4; i++) w[i] = key[i*32 +: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[7:0], t[31:8]};
            for (int j = 0; j < 4; j++) t[j*8 +: 8] = sbox(t[j*8 +: 8]);
            t[7:0] = t[7:0] ^ rc;
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int i = 0; i < 44; i++) o[i*32 +: 32] = w[i];
      return o;
   endfunction

   // ---------------- environment wiring ----------------
   logic [1407:0] rks0, rks1;
   logic          hyg;
   logic [127:0]  rnd_rk, rnd_dp;
   logic [127:0]  p1a, p1b;

   assign if0.rk_i = hyg ? rnd_rk :
                     (if0.rk_round_o <= 4'd10) ? rks0[32'(if0.rk_round_o)*128 +: 128] : '0;
   assign if0.dp_result_i = hyg ? rnd_dp : round_fn(if0.dp_state_o, if0.rk_i, if0.dp_last_o);

   assign if1.rk_i = (if1.rk_round_o <= 4'd10) ? rks1[32'(if1.rk_round_o)*128 +: 128] : '0;
   // two-stage delay line models DP_LAT=2
   always @(posedge clk) begin
      p1a <= round_fn(if1.dp_state_o, if1.rk_i, if1.dp_last_o);
      p1b <= p1a;
   end
   assign if1.dp_result_i = p1b;

   // ---------------- checking ----------------
   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic chki(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   task automatic fail_now(input string nm);
      checks++;
      failures++;
      $display("FAIL %s timed out", nm);
   endtask

   logic [127:0] q0[$], q1[$];
   logic         m_ov [2], m_or [2], m_iv [2], m_ir [2], m_ds [2], m_dl [2];
   logic [127:0] m_ob [2];
   int           acc_cyc [2], last_st [2], nst [2];
   logic         prev_ov [2];
   int           LATP [2];

   assign m_ov[0] = if0.out_valid;  assign m_ov[1] = if1.out_valid;
   assign m_or[0] = if0.out_ready;  assign m_or[1] = if1.out_ready;
   assign m_iv[0] = if0.in_valid;   assign m_iv[1] = if1.in_valid;
   assign m_ir[0] = if0.in_ready;   assign m_ir[1] = if1.in_ready;
   assign m_ds[0] = if0.dp_start_o; assign m_ds[1] = if1.dp_start_o;
   assign m_dl[0] = if0.dp_last_o;  assign m_dl[1] = if1.dp_last_o;
   assign m_ob[0] = if0.out_block;  assign m_ob[1] = if1.out_block;

   task automatic mon(input int d);
      logic [127:0] e;
      if (m_iv[d] === 1'b1 && m_ir[d] === 1'b1) begin
         acc_cyc[d] = cyc;
         nst[d]     = 0;
      end
      if (m_ds[d] === 1'b1) begin
         nst[d]++;
         if (nst[d] > 1) chki("dp_start spacing", cyc - last_st[d], LATP[d] + 1);
         chki("dp_last on start", int'(m_dl[d]), (nst[d] == 10) ? 1 : 0);
         last_st[d] = cyc;
      end
      if (m_ov[d] === 1'b1 && prev_ov[d] !== 1'b1) begin
         chki("accept-to-out_valid latency", cyc - acc_cyc[d], 1 + 10 * (LATP[d] + 1));
         chki("dp_start pulses per block", nst[d], 10);
      end
      if (m_ov[d] === 1'b1 && m_or[d] === 1'b1) begin
         if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            checks++;
            failures++;
            $display("FAIL unexpected output dut%0d actual=%h required=none", d, m_ob[d]);
         end else begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            chk("ciphertext", m_ob[d], e);
         end
      end
      prev_ov[d] = m_ov[d];
   endtask

   always @(negedge clk) begin
      mon(0);
      mon(1);
   end

   // ---------------- stimulus ----------------
   // call at posedge+1; returns at posedge+1 after the accept edge
   task automatic send(input int d, input logic [127:0] pt_hex, input logic [127:0] ct_hex,
                       input bit keep, output int acc);
      acc = -1;
      if (d == 0) begin
         if0.in_valid = 1'b1; if0.in_block = bswap(pt_hex); q0.push_back(bswap(ct_hex));
      end else begin
         if1.in_valid = 1'b1; if1.in_block = bswap(pt_hex); q1.push_back(bswap(ct_hex));
      end
      for (int i = 0; i < 100 && acc < 0; i++) begin
         @(negedge clk);
         if ((d == 0) ? (if0.in_ready === 1'b1) : (if1.in_ready === 1'b1)) acc = cyc;
      end
      if (acc < 0) fail_now("accept");
      @(posedge clk); #1;
      if (!keep) begin
         if (d == 0) if0.in_valid = 1'b0; else if1.in_valid = 1'b0;
      end
   endtask

   task automatic drain(input int d);
      bit done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         done = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
      end
      if (!done) fail_now("scoreboard drain");
      @(posedge clk); #1;
   endtask

   localparam logic [127:0] K_C1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] P_C1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] K_2B = 128'h2b7e151628aed2a6abf7158809cf4f3c;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int a, a1, a2, a3;
      bit seen;
      LATP[0] = 0; LATP[1] = 2;
      for (int d = 0; d < 2; d++) begin
         acc_cyc[d] = 0; last_st[d] = 0; nst[d] = 0; prev_ov[d] = 1'b0;
      end
      hyg = 1'b0; rnd_rk = '0; rnd_dp = '0;
      rks0 = expand(bswap(K_C1));
      rks1 = expand(bswap(K_C1));
      rst0 = 1'b1; rst1 = 1'b1;
      if0.in_valid = 1'b0; if0.in_block = '0; if0.out_ready = 1'b1;
      if1.in_valid = 1'b0; if1.in_block = '0; if1.out_ready = 1'b1;

      // reset state
      #12;
      chki("reset in_ready", int'(if0.in_ready), 1);
      chki("reset out_valid", int'(if0.out_valid), 0);
      chki("reset busy", int'(if0.busy), 0);
      chki("reset dp_start", int'(if0.dp_start_o), 0);
      chk("reset out_block", if0.out_block, '0);
      chki("reset rk_round", int'(if0.rk_round_o), 0);
      chki("reset in_ready dut1", int'(if1.in_ready), 1);
      chki("reset busy dut1", int'(if1.busy), 0);
      @(posedge clk); #1;
      rst0 = 1'b0; rst1 = 1'b0;

      // FIPS-197 C.1, combinational datapath
      send(0, P_C1, C_C1, 1'b0, a);
      drain(0);

      // backpressure in DONE
      if0.out_ready = 1'b0;
      send(0, P_C1, C_C1, 1'b0, a);
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         seen = (if0.out_valid === 1'b1);
      end
      if (!seen) fail_now("out_valid under backpressure");
      @(posedge clk); #1;
      if0.in_valid = 1'b1; if0.in_block = bswap(128'h3243f6a8885a308d313198a2e0370734);
      repeat (20) begin
         @(negedge clk);
         chki("held out_valid", int'(if0.out_valid), 1);
         chk("held out_block", if0.out_block, bswap(C_C1));
         chki("held in_ready", int'(if0.in_ready), 0);
      end
      @(posedge clk); #1;
      if0.in_valid = 1'b0; if0.out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chki("in_ready after release", int'(if0.in_ready), 1);
      chki("out_valid after release", int'(if0.out_valid), 0);
      @(posedge clk); #1;

      // asynchronous reset at round 5
      send(0, P_C1, C_C1, 1'b0, a);
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         seen = (if0.rk_round_o == 4'd5) && (if0.busy === 1'b1);
      end
      if (!seen) fail_now("reach round 5");
      #1 rst0 = 1'b1;
      #1;
      chki("async rst in_ready", int'(if0.in_ready), 1);
      chki("async rst out_valid", int'(if0.out_valid), 0);
      chki("async rst dp_start", int'(if0.dp_start_o), 0);
      chki("async rst busy", int'(if0.busy), 0);
      chki("async rst dp_last", int'(if0.dp_last_o), 0);
      chki("async rst rk_round", int'(if0.rk_round_o), 0);
      chk("async rst out_block", if0.out_block, '0);
      q0.delete();
      @(posedge clk); #1;
      rst0 = 1'b0;
      send(0, P_C1, C_C1, 1'b0, a);
      drain(0);

      // back-to-back, SP800-38A ECB-AES128 vectors
      rks0 = expand(bswap(K_2B));
      send(0, 128'h6bc1bee22e409f96e93d7e117393172a, 128'h3ad77bb40d7a3660a89ecaf32466ef97, 1'b1, a1);
      send(0, 128'hae2d8a571e03ac9c9eb76fac45af8e51, 128'hf5d3d58503b9699de785895a96fdbaaf, 1'b1, a2);
      send(0, 128'h30c81c46a35ce411e5fbc1191a0a52ef, 128'h43b1cd7f598ece23881b00e3ed030688, 1'b0, a3);
      chki("accept spacing 1-2", a2 - a1, 12);
      chki("accept spacing 2-3", a3 - a2, 12);
      drain(0);

      // idle hygiene
      hyg = 1'b1;
      repeat (20) begin
         if0.out_ready = 1'($urandom_range(0, 1));
         rnd_rk = {$urandom, $urandom, $urandom, $urandom};
         rnd_dp = {$urandom, $urandom, $urandom, $urandom};
         @(negedge clk);
         chki("idle out_valid", int'(if0.out_valid), 0);
         chki("idle dp_start", int'(if0.dp_start_o), 0);
         chki("idle busy", int'(if0.busy), 0);
         @(posedge clk); #1;
      end
      hyg = 1'b0; if0.out_ready = 1'b1;

      // DP_LAT=2 instance
      send(1, P_C1, C_C1, 1'b0, a);
      drain(1);
      rks1 = expand(bswap(K_2B));
      send(1, 128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32, 1'b0, a);
      drain(1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
